// File: rtl/ov_dvp_tx_if.sv
// DVP video bus between ov_dvp_tx (camera side) and the capture path.
// Signal names match the OV2640 capture interface they stand in for.
interface ov_dvp_tx_if;
    logic       VSYNC_OV;
    logic       HREF_OV;
    logic [7:0] OV_Data_out;

    modport master (output VSYNC_OV, output HREF_OV, output OV_Data_out);
    modport slave  (input  VSYNC_OV, input  HREF_OV, input  OV_Data_out);
endinterface

// File: rtl/ov_dvp_tx.sv
// ov_dvp_tx: OV2640-style RGB565 DVP transmitter driven by internal test patterns.
// Define OV_DVP_TX_CRC_EN to add frame_crc (CRC-16-CCITT over each frame's HREF bytes).
module ov_dvp_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] fill_rgb,
    ov_dvp_tx_if.master dvp,
    output logic        frame_done,
    output logic        busy
`ifdef OV_DVP_TX_CRC_EN
    ,
    output logic [15:0] frame_crc
`endif
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int ACT_LEN  = 2 * H_ACTIVE;
    localparam int VS_LEN   = VSYNC_LINES * LINE_LEN;
    localparam int VB_LEN   = V_BACK * LINE_LEN;
    localparam int VF_LEN   = V_FRONT * LINE_LEN;
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int M1       = (VS_LEN > VB_LEN) ? VS_LEN : VB_LEN;
    localparam int M2       = (M1 > VF_LEN) ? M1 : VF_LEN;
    localparam int M3       = (M2 > ACT_LEN) ? M2 : ACT_LEN;
    localparam int MAX_LEN  = (M3 > H_BLANK) ? M3 : H_BLANK;
    localparam int CW       = $clog2(MAX_LEN + 1);
    localparam int YW       = $clog2(V_ACTIVE + 1);

    localparam logic [CW-1:0] VS_LAST  = CW'(VS_LEN - 1);
    localparam logic [CW-1:0] VB_LAST  = CW'(VB_LEN - 1);
    localparam logic [CW-1:0] VF_LAST  = CW'(VF_LEN - 1);
    localparam logic [CW-1:0] ACT_LAST = CW'(ACT_LEN - 1);
    localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACT    = 3'd3;
    localparam logic [2:0] S_HBLANK = 3'd4;
    localparam logic [2:0] S_VFRONT = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [YW-1:0] y_q, y_d;
    logic [1:0]    pat_q, pat_d;
    logic [15:0]   fill_q, fill_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          start;
    logic [15:0]   x_w, y_w, pix;
    logic [2:0]    bar_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        y_d     = y_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                start = en;
            end
            S_VSYNC:
                if (cnt_q == VS_LAST) begin
                    state_d = S_VBACK;
                    cnt_d   = '0;
                end
            S_VBACK:
                if (cnt_q == VB_LAST) begin
                    state_d = S_ACT;
                    cnt_d   = '0;
                    y_d     = '0;
                end
            S_ACT:
                if (cnt_q == ACT_LAST) begin
                    state_d = S_HBLANK;
                    cnt_d   = '0;
                end
            S_HBLANK:
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = S_VFRONT;
                    end else begin
                        state_d = S_ACT;
                        y_d     = y_q + YW'(1);
                    end
                end
            S_VFRONT:
                if (cnt_q == VF_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    start   = en;
                end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (start) begin
            state_d = S_VSYNC;
            cnt_d   = '0;
            pat_d   = pattern_sel;
            fill_d  = fill_rgb;
        end
    end

    // Outputs are decoded from next-state values so they leave the flops aligned with state_q.
    always_comb begin
        x_w     = 16'(cnt_d >> 1);
        y_w     = 16'(y_d);
        bar_idx = 3'(x_w / 16'(BAR_W));
        pix     = '0;
        case (pat_d)
            2'd0:
                case (bar_idx)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            2'd1:    pix = {x_w[4:0], x_w[5:0], x_w[4:0]};
            2'd2:    pix = (((x_w ^ y_w) & 16'h0010) != 16'h0000) ? 16'hFFFF : 16'h0000;
            default: pix = fill_d;
        endcase
        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACT);
        data_d  = href_d ? (cnt_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
        done_d  = (state_d == S_VFRONT) && (cnt_d == VF_LAST);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            pat_q   <= '0;
            fill_q  <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign dvp.VSYNC_OV    = vsync_q;
    assign dvp.HREF_OV     = href_q;
    assign dvp.OV_Data_out = data_q;
    assign frame_done      = done_q;
    assign busy            = busy_q;

`ifdef OV_DVP_TX_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] fcrc_q, fcrc_d;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic [7:0]  d;
        r = c;
        d = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[15] ^ d[7]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
            d = {d[6:0], 1'b0};
        end
        return r;
    endfunction

    // The done edge never carries an HREF byte, so crc_q is already final there.
    always_comb begin
        crc_d  = crc_q;
        fcrc_d = fcrc_q;
        if (start)       crc_d = 16'hFFFF;
        else if (href_d) crc_d = crc16_byte(crc_q, data_d);
        if (done_d)      fcrc_d = crc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q  <= 16'hFFFF;
            fcrc_q <= 16'h0000;
        end else begin
            crc_q  <= crc_d;
            fcrc_q <= fcrc_d;
        end
    end

    assign frame_crc = fcrc_q;
`endif

endmodule

// File: tb/tb_ov_dvp_tx.sv
// Directed self-checking bench for ov_dvp_tx with a 20-cycle line, 140-cycle frame.
module tb_ov_dvp_tx;
    localparam int FRAME = 140;
    localparam int ACT0  = 40;
    localparam int NCAP  = 320;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] fill_rgb = 16'h0000;
    logic        frame_done;
    logic        busy;
`ifdef OV_DVP_TX_CRC_EN
    logic [15:0] frame_crc;
`endif

    ov_dvp_tx_if dvp_bus ();

    ov_dvp_tx #(
        .H_ACTIVE   (8),
        .V_ACTIVE   (4),
        .H_BLANK    (4),
        .VSYNC_LINES(1),
        .V_BACK     (1),
        .V_FRONT    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pattern_sel(pattern_sel),
        .fill_rgb   (fill_rgb),
        .dvp        (dvp_bus),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef OV_DVP_TX_CRC_EN
        ,
        .frame_crc  (frame_crc)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        vs_a [NCAP];
    logic        hr_a [NCAP];
    logic        dn_a [NCAP];
    logic        bz_a [NCAP];
    logic [7:0]  dt_a [NCAP];
    logic [15:0] crc_a [NCAP];

    logic [7:0] bars [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                              8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench #1 after the edge that raised VSYNC_OV (frame cycle 0).
    task automatic restart_frame(input logic [1:0] sel, input logic [15:0] fill);
        tick();
        rst_n = 1'b0;
        en = 1'b1;
        pattern_sel = sel;
        fill_rgb = fill;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic capture(input int n, input int chg_at, input logic en_new,
                           input logic [1:0] sel_new, input logic [15:0] fill_new);
        for (int i = 0; i < n; i++) begin
            vs_a[i] = dvp_bus.VSYNC_OV;
            hr_a[i] = dvp_bus.HREF_OV;
            dt_a[i] = dvp_bus.OV_Data_out;
            dn_a[i] = frame_done;
            bz_a[i] = busy;
`ifdef OV_DVP_TX_CRC_EN
            crc_a[i] = frame_crc;
`else
            crc_a[i] = 16'h0000;
`endif
            if (i == chg_at) begin
                en = en_new;
                pattern_sel = sel_new;
                fill_rgb = fill_new;
            end
            tick();
        end
    endtask

    function automatic logic [15:0] crc_ref(input int nbytes, input logic [7:0] b);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < nbytes; k++) begin
            for (int j = 7; j >= 0; j--) begin
                if (c[15] ^ b[j]) c = {c[14:0], 1'b0} ^ 16'h1021;
                else              c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    task automatic test_reset();
        en = 1'b1;
        rst_n = 1'b0;
        pattern_sel = 2'd0;
        tick();
        tick();
        checks++;
        if ({dvp_bus.VSYNC_OV, dvp_bus.HREF_OV, frame_done, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {dvp_bus.VSYNC_OV, dvp_bus.HREF_OV, frame_done, busy});
        end
        checks++;
        if (dvp_bus.OV_Data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00", dvp_bus.OV_Data_out);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({dvp_bus.VSYNC_OV, busy} !== 2'b11) begin
            errors++;
            $display("FAIL vsync_after_release: got %b expected 11", {dvp_bus.VSYNC_OV, busy});
        end
    endtask

    task automatic test_timing();
        int vs_len, first_rise, npulse, bad_pulse, ndone, done_at, bad_data, bad_busy;
        int starts [8];
        int lens [8];
        restart_frame(2'd0, 16'h0000);
        capture(FRAME + 1, -1, 1'b1, 2'd0, 16'h0000);
        vs_len = 0;
        while (vs_len < FRAME && vs_a[vs_len] === 1'b1) vs_len++;
        checks++;
        if (vs_len !== 20) begin
            errors++;
            $display("FAIL vsync_len: got %0d expected 20", vs_len);
        end
        npulse = 0;
        first_rise = -1;
        for (int i = 0; i < FRAME; i++) begin
            if (hr_a[i] === 1'b1 && (i == 0 || hr_a[i-1] !== 1'b1)) begin
                if (first_rise < 0) first_rise = i;
                if (npulse < 8) begin
                    starts[npulse] = i;
                    lens[npulse] = 0;
                end
                npulse++;
            end
            if (hr_a[i] === 1'b1 && npulse > 0 && npulse <= 8) lens[npulse-1]++;
        end
        checks++;
        if (first_rise !== ACT0) begin
            errors++;
            $display("FAIL href_first_rise: got %0d expected %0d", first_rise, ACT0);
        end
        checks++;
        if (npulse !== 4) begin
            errors++;
            $display("FAIL href_pulses: got %0d expected 4", npulse);
        end
        bad_pulse = 0;
        for (int p = 0; p < 4 && p < npulse; p++)
            if (starts[p] != ACT0 + 20 * p || lens[p] != 16) bad_pulse++;
        checks++;
        if (bad_pulse !== 0) begin
            errors++;
            $display("FAIL href_shape: got %0d bad pulses expected 0", bad_pulse);
        end
        ndone = 0;
        done_at = -1;
        bad_data = 0;
        bad_busy = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (dn_a[i] === 1'b1) begin
                ndone++;
                done_at = i;
            end
            if (hr_a[i] !== 1'b1 && dt_a[i] !== 8'h00) bad_data++;
            if (bz_a[i] !== 1'b1) bad_busy++;
        end
        checks++;
        if (ndone !== 1 || done_at !== FRAME - 1) begin
            errors++;
            $display("FAIL frame_done: got %0d pulses at %0d expected 1 at %0d", ndone, done_at, FRAME - 1);
        end
        checks++;
        if (bad_data !== 0) begin
            errors++;
            $display("FAIL data_when_idle: got %0d nonzero bytes expected 0", bad_data);
        end
        checks++;
        if (bad_busy !== 0) begin
            errors++;
            $display("FAIL busy_in_frame: got %0d low cycles expected 0", bad_busy);
        end
        checks++;
        if (vs_a[FRAME] !== 1'b1) begin
            errors++;
            $display("FAIL vsync_rerise: got %b expected 1", vs_a[FRAME]);
        end
    endtask

    task automatic test_colour_bars();
        restart_frame(2'd0, 16'h0000);
        capture(FRAME, -1, 1'b1, 2'd0, 16'h0000);
        for (int l = 0; l < 4; l++) begin
            int bad;
            logic [7:0] got, exp_b;
            bad = 0;
            got = 8'h00;
            exp_b = 8'h00;
            for (int b = 0; b < 16; b++) begin
                if (dt_a[ACT0 + 20 * l + b] !== bars[b] || hr_a[ACT0 + 20 * l + b] !== 1'b1) begin
                    if (bad == 0) begin
                        got = dt_a[ACT0 + 20 * l + b];
                        exp_b = bars[b];
                    end
                    bad++;
                end
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL bars_line%0d: got %h expected %h (%0d bad bytes)", l, got, exp_b, bad);
            end
        end
    endtask

    task automatic test_patterns();
        int bad_fill, bad_next, bad_chk, bad_grad;
        logic [15:0] gp;
        // Fill frame with a mid-frame select change that must only affect the next frame.
        restart_frame(2'd3, 16'hA5C3);
        capture(2 * FRAME, 60, 1'b1, 2'd0, 16'h0000);
        bad_fill = 0;
        bad_next = 0;
        for (int l = 0; l < 4; l++)
            for (int b = 0; b < 16; b++) begin
                if (dt_a[ACT0 + 20 * l + b] !== ((b % 2 == 0) ? 8'hA5 : 8'hC3)) bad_fill++;
                if (dt_a[FRAME + ACT0 + 20 * l + b] !== bars[b]) bad_next++;
            end
        checks++;
        if (bad_fill !== 0) begin
            errors++;
            $display("FAIL fill_pattern: got %0d bad bytes expected 0", bad_fill);
        end
        checks++;
        if (bad_next !== 0) begin
            errors++;
            $display("FAIL sel_next_frame: got %0d bad bytes expected 0", bad_next);
        end
        // Checkerboard: x,y < 16 keeps x[4]^y[4] = 0, so every pixel is 0000.
        restart_frame(2'd2, 16'h1234);
        capture(FRAME, -1, 1'b1, 2'd2, 16'h1234);
        bad_chk = 0;
        for (int l = 0; l < 4; l++)
            for (int b = 0; b < 16; b++)
                if (dt_a[ACT0 + 20 * l + b] !== 8'h00 || hr_a[ACT0 + 20 * l + b] !== 1'b1) bad_chk++;
        checks++;
        if (bad_chk !== 0) begin
            errors++;
            $display("FAIL checker_pattern: got %0d bad bytes expected 0", bad_chk);
        end
        restart_frame(2'd1, 16'h0000);
        capture(FRAME, -1, 1'b1, 2'd1, 16'h0000);
        bad_grad = 0;
        for (int l = 0; l < 4; l++)
            for (int b = 0; b < 16; b++) begin
                gp = 16'h0821 * 16'(b / 2);
                if (dt_a[ACT0 + 20 * l + b] !== ((b % 2 == 0) ? gp[15:8] : gp[7:0])) bad_grad++;
            end
        checks++;
        if (bad_grad !== 0) begin
            errors++;
            $display("FAIL gradient_pattern: got %0d bad bytes expected 0", bad_grad);
        end
    endtask

    task automatic test_stop_continue();
        int idle_bad;
        restart_frame(2'd0, 16'h0000);
        capture(300, FRAME + 60, 1'b0, 2'd0, 16'h0000);
        checks++;
        if ({dn_a[FRAME - 1], vs_a[FRAME - 1], vs_a[FRAME]} !== 3'b101) begin
            errors++;
            $display("FAIL continue_frame: got %b expected 101",
                     {dn_a[FRAME - 1], vs_a[FRAME - 1], vs_a[FRAME]});
        end
        checks++;
        if ({dn_a[2 * FRAME - 1], bz_a[2 * FRAME - 1]} !== 2'b11) begin
            errors++;
            $display("FAIL stop_last_frame_done: got %b expected 11",
                     {dn_a[2 * FRAME - 1], bz_a[2 * FRAME - 1]});
        end
        idle_bad = 0;
        for (int i = 2 * FRAME; i < 300; i++)
            if (vs_a[i] !== 1'b0 || hr_a[i] !== 1'b0 || bz_a[i] !== 1'b0 || dn_a[i] !== 1'b0) idle_bad++;
        checks++;
        if (idle_bad !== 0) begin
            errors++;
            $display("FAIL stop_idle: got %0d active cycles expected 0", idle_bad);
        end
    endtask

    task automatic test_abort();
        restart_frame(2'd3, 16'h0000);
        capture(190, -1, 1'b1, 2'd3, 16'h0000);
        checks++;
        if (hr_a[189] !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup_href: got %b expected 1", hr_a[189]);
        end
`ifdef OV_DVP_TX_CRC_EN
        checks++;
        if (crc_a[FRAME - 2] !== 16'h0000) begin
            errors++;
            $display("FAIL crc_before_done: got %h expected 0000", crc_a[FRAME - 2]);
        end
        checks++;
        if (crc_a[FRAME - 1] !== crc_ref(64, 8'h00) || crc_a[185] !== crc_ref(64, 8'h00)) begin
            errors++;
            $display("FAIL crc_zero_frame: got %h/%h expected %h",
                     crc_a[FRAME - 1], crc_a[185], crc_ref(64, 8'h00));
        end
`endif
        rst_n = 1'b0;
        tick();
        checks++;
        if ({dvp_bus.VSYNC_OV, dvp_bus.HREF_OV, frame_done, busy, dvp_bus.OV_Data_out} !== 12'h000) begin
            errors++;
            $display("FAIL abort_outputs: got %h expected 000",
                     {dvp_bus.VSYNC_OV, dvp_bus.HREF_OV, frame_done, busy, dvp_bus.OV_Data_out});
        end
`ifdef OV_DVP_TX_CRC_EN
        checks++;
        if (frame_crc !== 16'h0000) begin
            errors++;
            $display("FAIL abort_crc: got %h expected 0000", frame_crc);
        end
`endif
        en = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_timing();
        test_colour_bars();
        test_patterns();
        test_stop_continue();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
